// File: rtl/posit_accumulator_8bit.sv
// Posit<8,0> stream accumulator: folds a valid/ready vector of posits into one rounded sum.
// The adder forms the exact sum in fixed point and rounds once (nearest-even, saturating).

module posit_adder_8bit (
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    output logic [7:0] sum
);
    // Every posit<8,0> magnitude is a multiple of 2^-11 below 2^7, so a 20-bit signed sum is exact.
    function automatic logic signed [19:0] to_fixed(input logic [7:0] x);
        logic [7:0]  m;
        logic [6:0]  tail;
        logic [19:0] mag;
        logic        done;
        int          run;
        m    = x[7] ? 8'(-x) : x;
        run  = 0;
        done = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!done && m[i] == m[6]) run++;
            else done = 1'b1;
        end
        tail = m[6:0] << (run + 1);
        mag  = 20'({1'b1, tail[6:2]}) << (m[6] ? run + 5 : 6 - run);
        if (x == 8'h00) return 20'sd0;
        return x[7] ? -$signed(mag) : $signed(mag);
    endfunction

    logic signed [19:0] total;
    logic [19:0]        abs_sum;
    logic [18:0]        norm;
    logic [31:0]        body;
    logic [6:0]         pos;
    logic [6:0]         rounded;
    logic [6:0]         mag7;
    int                 p;
    int                 k;

    always_comb begin
        total   = to_fixed(lhs) + to_fixed(rhs);
        abs_sum = total[19] ? 20'(-total) : total;
        p = 0;
        for (int i = 0; i < 19; i++) begin
            if (abs_sum[i]) p = i;
        end
        k    = p - 11;
        norm = abs_sum[18:0] << (18 - p);
        // Regime run is built by shifting a "10"/"01" seed right and filling the vacated bits.
        if (k >= 0) body = ({2'b10, norm[17:0], 12'b0} >> k) | ~(32'hFFFF_FFFF >> k);
        else        body = {2'b01, norm[17:0], 12'b0} >> (-k - 1);
        pos     = body[31:25];
        rounded = pos + 7'(body[24] & (pos[0] | (|body[23:0])));
        if (k >= 6)       mag7 = 7'h7F;
        else if (k <= -7) mag7 = 7'h01;
        else              mag7 = rounded;
        if (lhs == 8'h80 || rhs == 8'h80) sum = 8'h80;
        else if (total == 20'sd0)         sum = 8'h00;
        else if (total[19])               sum = 8'(-{1'b0, mag7});
        else                              sum = {1'b0, mag7};
    end
endmodule

module posit_accumulator_8bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_nar,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);
    // Both streams transfer a beat only on a cycle where valid and ready are high together;
    // a pending result keeps out_data/out_nar/out_count frozen until it is taken.
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       acc;
    logic [7:0]       sum;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             acc_fire;

    posit_adder_8bit adder (
        .lhs (acc),
        .rhs (in_data),
        .sum (sum)
    );

    assign in_ready  = !flush && (state != HOLD || out_ready);
    assign acc_fire  = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state == ACC);
    assign count_inc = (&count) ? count : count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)                           state_next = IDLE;
        else if (acc_fire)                   state_next = in_last ? HOLD : ACC;
        else if (state == HOLD && out_ready) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 8'h00;
            count     <= '0;
            out_data  <= 8'h00;
            out_nar   <= 1'b0;
            out_count <= '0;
        end else if (flush) begin
            acc   <= 8'h00;
            count <= '0;
        end else if (acc_fire) begin
            if (in_last) begin
                out_data  <= sum;
                out_nar   <= (sum == 8'h80);
                out_count <= count_inc;
                acc       <= 8'h00;
                count     <= '0;
            end else begin
                acc   <= sum;
                count <= count_inc;
            end
        end
    end
endmodule

// File: tb/tb_posit_accumulator_8bit.sv
// Directed bench for posit_accumulator_8bit: sums, NaR, backpressure, flush, async reset,
// and count saturation on a narrow-counter instance.

module tb_posit_accumulator_8bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_nar;
    logic       busy;
    logic [7:0] out_data;
    logic [7:0] out_count;

    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_in_ready;
    logic       s_out_valid;
    logic       s_out_nar;
    logic       s_busy;
    logic [7:0] s_out_data;
    logic [1:0] s_out_count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    posit_accumulator_8bit #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_nar(out_nar), .out_count(out_count), .busy(busy)
    );

    posit_accumulator_8bit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(s_valid), .in_ready(s_in_ready), .in_data(s_data), .in_last(s_last),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
        .out_nar(s_out_nar), .out_count(s_out_count), .busy(s_busy)
    );

    // Presents one beat for one clock; caller guarantees in_ready is high at that edge.
    task automatic drive(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else passed++;
        checks++; if (out_count !== 8'd0) $display("FAIL reset_out_count got=%0d exp=0", out_count); else passed++;
        checks++; if (out_nar !== 1'b0) $display("FAIL reset_out_nar got=%b exp=0", out_nar); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sum2();
        out_ready = 1'b1;
        drive(8'h40, 1'b0);
        checks++; if (busy !== 1'b1) $display("FAIL sum2_busy got=%b exp=1", busy); else passed++;
        drive(8'h40, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL sum2_valid got=%b exp=1", out_valid); else passed++;
        checks++; if (out_data !== 8'h60) $display("FAIL sum2_data got=%h exp=60", out_data); else passed++;
        checks++; if (out_count !== 8'd2) $display("FAIL sum2_count got=%0d exp=2", out_count); else passed++;
        checks++; if (out_nar !== 1'b0) $display("FAIL sum2_nar got=%b exp=0", out_nar); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL sum2_consumed got=%b exp=0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(8'h40, 1'b0);
        drive(8'h60, 1'b0);
        drive(8'hC0, 1'b1);
        checks++; if (out_data !== 8'h60) $display("FAIL b2b_data got=%h exp=60", out_data); else passed++;
        checks++; if (out_count !== 8'd3) $display("FAIL b2b_count got=%0d exp=3", out_count); else passed++;
        drive(8'h40, 1'b0);
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_handoff_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_handoff_busy got=%b exp=1", busy); else passed++;
        drive(8'hC0, 1'b1);
        checks++; if (out_data !== 8'h00) $display("FAIL cancel_data got=%h exp=00", out_data); else passed++;
        checks++; if (out_nar !== 1'b0) $display("FAIL cancel_nar got=%b exp=0", out_nar); else passed++;
        checks++; if (out_count !== 8'd2) $display("FAIL cancel_count got=%0d exp=2", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_nar();
        out_ready = 1'b1;
        drive(8'h40, 1'b0);
        drive(8'h80, 1'b0);
        drive(8'h40, 1'b1);
        checks++; if (out_data !== 8'h80) $display("FAIL nar_data got=%h exp=80", out_data); else passed++;
        checks++; if (out_nar !== 1'b1) $display("FAIL nar_flag got=%b exp=1", out_nar); else passed++;
        checks++; if (out_count !== 8'd3) $display("FAIL nar_count got=%0d exp=3", out_count); else passed++;
        drive(8'h50, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL reload_valid got=%b exp=1", out_valid); else passed++;
        checks++; if (out_data !== 8'h50) $display("FAIL after_nar_data got=%h exp=50", out_data); else passed++;
        checks++; if (out_nar !== 1'b0) $display("FAIL after_nar_flag got=%b exp=0", out_nar); else passed++;
        checks++; if (out_count !== 8'd1) $display("FAIL after_nar_count got=%0d exp=1", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(8'h40, 1'b0);
        drive(8'h50, 1'b1);
        checks++; if (out_data !== 8'h64) $display("FAIL bp_sum_data got=%h exp=64", out_data); else passed++;
        checks++; if (out_count !== 8'd2) $display("FAIL bp_sum_count got=%0d exp=2", out_count); else passed++;
        in_valid = 1'b1;
        in_data  = 8'h40;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); else passed++;
            @(posedge clk); #1;
            checks++; if (out_data !== 8'h64 || out_valid !== 1'b1) $display("FAIL bp_hold cyc=%0d got=%h/%b exp=64/1", i, out_data, out_valid); else passed++;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_reload_valid got=%b exp=1", out_valid); else passed++;
        checks++; if (out_data !== 8'h40) $display("FAIL bp_reload_data got=%h exp=40", out_data); else passed++;
        checks++; if (out_count !== 8'd1) $display("FAIL bp_reload_count got=%0d exp=1", out_count); else passed++;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(8'h40, 1'b0);
        drive(8'h40, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h40;
        in_last  = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", in_ready); else passed++;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", out_valid); else passed++;
        drive(8'h68, 1'b1);
        checks++; if (out_data !== 8'h68) $display("FAIL flush_next_data got=%h exp=68", out_data); else passed++;
        checks++; if (out_count !== 8'd1) $display("FAIL flush_next_count got=%0d exp=1", out_count); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(8'h40, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL areset_pre_valid got=%b exp=1", out_valid); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL areset_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (out_data !== 8'h00) $display("FAIL areset_data got=%h exp=00", out_data); else passed++;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL areset_idle got=%b/%b exp=1/0", in_ready, out_valid); else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        s_valid = 1'b1;
        s_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            s_last = (i == 4);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++; if (s_out_valid !== 1'b1) $display("FAIL sat_valid got=%b exp=1", s_out_valid); else passed++;
        checks++; if (s_out_count !== 2'd3) $display("FAIL sat_count got=%0d exp=3", s_out_count); else passed++;
        checks++; if (s_out_data !== 8'h00 || s_out_nar !== 1'b0) $display("FAIL sat_data got=%h/%b exp=00/0", s_out_data, s_out_nar); else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sum2();
        test_back_to_back();
        test_nar();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/posit_accumulator_8bit.md
Name: posit_accumulator_8bit

Overview:
- Sequential stream reducer that sums a vector of 8-bit posits into one 8-bit posit.
- Sits directly upstream of and around posit_adder_8bit: instantiates it once, feeding the running accumulator as lhs and the incoming element as rhs each accepted beat.
- Input side is a valid/ready element stream with an end-of-vector marker. Output side is a valid/ready result stream carrying the sum, an element count and a NaR flag.
- Used for dot-product/reduction tails in the posit datapath.

Parameters:
CNT_W, 8, width of the per-vector element counter; count saturates at 2^CNT_W-1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of the current vector and any pending result
in_valid  input  1  element presented
in_ready  output  1  element accepted when in_valid & in_ready
in_data  input  8  posit element
in_last  input  1  marks the final element of the vector; qualified by in_valid
out_valid  output  1  result presented
out_ready  input  1  result consumed when out_valid & out_ready
out_data  output  8  posit sum of the vector
out_nar  output  1  result is NaR (out_data == 8'h80)
out_count  output  CNT_W  elements in the vector (saturating)
busy  output  1  a vector is partially accumulated (state ACC)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, acc=8'h00, count=0.
  - out_valid=0, out_data=8'h00, out_nar=0, out_count=0, busy=0.
  - in_ready follows its combinational rule (1 in IDLE).
- Adder path: sum = posit_adder_8bit(lhs=acc, rhs=in_data), purely combinational. There is no other arithmetic on posit values.
- Accepted beat (acc_fire = in_valid & in_ready):
  - Not last: acc<=sum, count<=sat(count+1), state<=ACC.
  - Last: out_data<=sum, out_nar<=(sum==8'h80), out_count<=sat(count+1), out_valid<=1. Then acc<=8'h00, count<=0, state<=HOLD.
- Latency: the result appears on out_data the cycle after the last element is accepted. Throughput is one element per clock.
- States:
  - IDLE: no partial vector, no pending result. in_ready=1.
  - ACC: partial vector held. in_ready=1, busy=1.
  - HOLD: result pending. in_ready=out_ready.
- HOLD transitions:
  - out_fire and no acc_fire -> out_valid<=0, state<=IDLE.
  - out_fire and acc_fire (not last) -> out_valid<=0, state<=ACC. The new vector starts from acc=8'h00.
  - out_fire and acc_fire with in_last (1-element vector) -> out_* reloaded with the new result, out_valid stays 1, state stays HOLD.
  - No out_fire -> all out_* held stable, no input accepted.
- Output stability: out_data, out_nar and out_count must not change while out_valid=1 and out_ready=0.
- NaR:
  - 8'h80 on any element makes the adder produce NaR, and acc stays 8'h80 for the rest of the vector.
  - The result is 8'h80 with out_nar=1.
  - The next vector starts clean from 8'h00.
- Zero: an all-zero or cancelling vector yields out_data=8'h00, out_nar=0.
- Count saturation: count holds at 2^CNT_W-1 and does not wrap. Summation continues regardless.
- flush (highest priority, overrides every transition):
  - Next cycle: state=IDLE, acc=8'h00, count=0, out_valid=0.
  - Any beat presented that cycle is dropped, and in_ready is forced 0 during flush.
- rst_n asserted mid-vector or mid-HOLD: immediate return to reset values. The pending result is lost.
- in_last without a prior beat: valid 1-element vector; the result is in_data passed through the adder with 8'h00.

Test Plan:
- Vector [8'h40, 8'h40] with in_last on the 2nd beat, out_ready=1 -> one cycle after the 2nd beat: out_valid=1, out_data=8'h60 (2.0), out_count=2, out_nar=0.
- Vector [8'h40, 8'h60, 8'hC0] back-to-back (1+2-1) -> out_data=8'h60, out_count=3. Then vector [8'h40, 8'hC0] -> out_data=8'h00, out_nar=0.
- Vector [8'h40, 8'h80, 8'h40] -> out_data=8'h80, out_nar=1, out_count=3. Next vector [8'h50] -> out_data=8'h50, out_nar=0.
- Backpressure: result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data constant. Raising out_ready with new beat [8'h40, last] -> out_valid stays 1, out_data becomes 8'h40 next cycle.
- flush asserted after 2 accepted beats of a vector -> busy=0, no out_valid. New vector [8'h68, last] -> out_data=8'h68, out_count=1.
- rst_n pulsed low asynchronously mid-HOLD -> out_valid=0 and out_data=8'h00 immediately, without a clock edge. CNT_W=2 with a 5-element vector of 8'h00 -> out_count=3.
